// File: rtl/axil_pattern_master.sv
// rtl/axil_pattern_master.sv - AXI4-Lite write-then-readback memory test master
// Writes SEED + i*0x01010101 to NUM_WORDS words, reads them back, and reports mismatches or a stalled handshake.
module axil_pattern_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned NUM_WORDS = 16,
  parameter logic [31:0] SEED      = 32'hDEAD_BEEF,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic [31:0] first_err_addr,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_DONE
  } state_e;

  localparam logic [15:0] LAST_IDX   = 16'(NUM_WORDS - 1);
  localparam logic [31:0] WAIT_LAST  = 32'(TIMEOUT - 1);
  localparam bit          TIMEOUT_EN = (TIMEOUT != 0);

  state_e      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic [31:0] wait_q, wait_d;
  logic        timeout_q, timeout_d;
  logic [15:0] err_count_q, err_count_d;
  logic [31:0] first_err_q, first_err_d;

  logic [31:0] cur_addr;
  logic [31:0] cur_data;
  logic        last_word;
  logic        waiting;

  assign cur_addr  = BASE_ADDR + {14'd0, idx_q, 2'b00};
  assign cur_data  = SEED + ({16'd0, idx_q} * 32'h0101_0101);
  assign last_word = (idx_q == LAST_IDX);
  assign waiting   = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
                     (state_q == S_RD_REQ) || (state_q == S_RD_RESP);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      idx_q       <= 16'd0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wait_q      <= 32'd0;
      timeout_q   <= 1'b0;
      err_count_q <= 16'd0;
      first_err_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    wait_d      = 32'd0;
    timeout_d   = timeout_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_WR_REQ;
          idx_d       = 16'd0;
          awvalid_d   = 1'b1;
          wvalid_d    = 1'b1;
          timeout_d   = 1'b0;
          err_count_d = 16'd0;
          first_err_d = 32'd0;
        end
      end
      S_WR_REQ: begin
        // Address and data channels retire independently, in either order.
        if (awvalid_q && mem_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && mem_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)      state_d   = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (mem_axi_bvalid) begin
          if (last_word) begin
            idx_d   = 16'd0;
            state_d = S_RD_REQ;
          end else begin
            idx_d     = idx_q + 16'd1;
            state_d   = S_WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end
      end
      S_RD_REQ: begin
        if (mem_axi_arready) state_d = S_RD_RESP;
      end
      S_RD_RESP: begin
        if (mem_axi_rvalid) begin
          if (mem_axi_rdata != cur_data) begin
            if (err_count_q == 16'd0)     first_err_d = cur_addr;
            if (err_count_q != 16'hFFFF)  err_count_d = err_count_q + 16'd1;
          end
          if (last_word) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 16'd1;
            state_d = S_RD_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A completing handshake on the final allowed cycle wins over the abort.
    if (waiting && (state_d == state_q)) begin
      if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
        state_d   = S_DONE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        timeout_d = 1'b1;
      end else begin
        wait_d = wait_q + 32'd1;
      end
    end
  end

  assign busy            = waiting;
  assign done            = (state_q == S_DONE);
  assign pass            = done && (err_count_q == 16'd0) && !timeout_q;
  assign timeout         = timeout_q;
  assign err_count       = err_count_q;
  assign first_err_addr  = first_err_q;

  assign mem_axi_awvalid = awvalid_q;
  assign mem_axi_awaddr  = cur_addr;
  assign mem_axi_awprot  = 3'b000;
  assign mem_axi_wvalid  = wvalid_q;
  assign mem_axi_wdata   = cur_data;
  assign mem_axi_wstrb   = 4'b1111;
  assign mem_axi_bready  = (state_q == S_WR_RESP);
  assign mem_axi_arvalid = (state_q == S_RD_REQ);
  assign mem_axi_araddr  = cur_addr;
  assign mem_axi_arprot  = 3'b000;
  assign mem_axi_rready  = (state_q == S_RD_RESP);

endmodule

// File: tb/tb_axil_pattern_master.sv
// tb/tb_axil_pattern_master.sv - self-checking bench for axil_pattern_master
// A behavioural AXI-Lite memory responds with configurable stalls and read corruption.
module tb_axil_pattern_master;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          NW   = 4;
  localparam logic [31:0] SEED = 32'hDEAD_BEEF;
  localparam int          TO   = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;
  logic        mem_axi_awvalid, mem_axi_awready = 1'b0;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid, mem_axi_wready = 1'b0;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid = 1'b0, mem_axi_bready;
  logic        mem_axi_arvalid, mem_axi_arready = 1'b0;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid = 1'b0, mem_axi_rready;
  logic [31:0] mem_axi_rdata = 32'd0;

  always #5 clk = ~clk;

  axil_pattern_master #(
    .BASE_ADDR(BASE), .NUM_WORDS(NW), .SEED(SEED), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
    .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
    .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
    .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
    .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
    .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
    .mem_axi_rdata(mem_axi_rdata)
  );

  int          aw_delay = 0, w_delay = 0;
  bit          rand_delays = 0;
  bit          ar_enable = 1;
  logic [NW-1:0] corrupt_mask = '0;

  int          aw_cnt = 0, w_cnt = 0;
  bit          aw_got = 0, w_got = 0, ar_got = 0, b_hs = 0, r_hs = 0;
  logic [31:0] aw_addr_c, w_data_c, ar_addr_c, aw_first, w_first;
  bit          aw_unstable = 0, w_unstable = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wlog_addr[$], wlog_data[$], rlog_addr[$];
  int          aw_hi[$], w_hi[$];
  int          n_b = 0, arv_cycles = 0;

  int n_checks = 0;
  int n_errs = 0;

  // Responder: decides ready/valid at the falling edge; a handshake seen here completes at the next rising edge.
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      mem_axi_awready = 0; mem_axi_wready = 0; mem_axi_arready = 0;
      mem_axi_bvalid = 0; mem_axi_rvalid = 0;
      aw_cnt = 0; w_cnt = 0; aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
    end else begin
      mem_axi_awready = 0; mem_axi_wready = 0; mem_axi_arready = 0;
      if (b_hs) begin mem_axi_bvalid = 0; b_hs = 0; end
      if (r_hs) begin mem_axi_rvalid = 0; r_hs = 0; end
      if (aw_got && w_got && !mem_axi_bvalid) mem_axi_bvalid = 1;
      if (mem_axi_bvalid && mem_axi_bready) begin
        b_hs = 1; mem[aw_addr_c] = w_data_c;
        wlog_addr.push_back(aw_addr_c); wlog_data.push_back(w_data_c);
        aw_got = 0; w_got = 0; n_b++;
      end
      if (ar_got && !mem_axi_rvalid) begin
        int wi;
        wi = int'((ar_addr_c - BASE) >> 2);
        mem_axi_rvalid = 1;
        mem_axi_rdata = mem.exists(ar_addr_c) ? mem[ar_addr_c] : 32'hBAD0_BAD0;
        if (wi >= 0 && wi < NW && corrupt_mask[wi]) mem_axi_rdata = mem_axi_rdata ^ 32'd1;
      end
      if (mem_axi_rvalid && mem_axi_rready) begin r_hs = 1; ar_got = 0; end
      if (mem_axi_awvalid) begin
        if (aw_cnt == 0) aw_first = mem_axi_awaddr;
        else if (mem_axi_awaddr !== aw_first) aw_unstable = 1;
        if (aw_cnt >= aw_delay) begin
          mem_axi_awready = 1; aw_got = 1; aw_addr_c = mem_axi_awaddr;
          aw_hi.push_back(aw_cnt + 1); aw_cnt = 0;
          if (rand_delays) aw_delay = $urandom_range(0, 3);
        end else aw_cnt++;
      end
      if (mem_axi_wvalid) begin
        if (w_cnt == 0) w_first = mem_axi_wdata;
        else if (mem_axi_wdata !== w_first) w_unstable = 1;
        if (w_cnt >= w_delay) begin
          mem_axi_wready = 1; w_got = 1; w_data_c = mem_axi_wdata;
          w_hi.push_back(w_cnt + 1); w_cnt = 0;
          if (rand_delays) w_delay = $urandom_range(0, 3);
        end else w_cnt++;
      end
      if (mem_axi_arvalid) begin
        arv_cycles++;
        if (ar_enable) begin
          mem_axi_arready = 1; ar_got = 1; ar_addr_c = mem_axi_araddr;
          rlog_addr.push_back(mem_axi_araddr);
        end
      end
    end
  end

  function automatic logic [31:0] exp_addr(input int i);
    return BASE + 32'(i) * 32'd4;
  endfunction

  function automatic logic [31:0] exp_data(input int i);
    return SEED + 32'(i) * 32'h0101_0101;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic clear_logs();
    wlog_addr.delete(); wlog_data.delete(); rlog_addr.delete();
    aw_hi.delete(); w_hi.delete();
    n_b = 0; arv_cycles = 0; aw_unstable = 0; w_unstable = 0;
  endtask

  task automatic start_run();
    @(negedge clk);
    clear_logs();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 600 && !done; k++) @(negedge clk);
    chk({tag, "_done_reached"}, 32'(done), 32'd1);
  endtask

  // Reference: every word written once in order, every word read back in order.
  task automatic check_full_run(input string tag, input logic [NW-1:0] mask);
    int          exp_err;
    logic [31:0] exp_first;
    exp_err = $countones(mask);
    exp_first = 32'd0;
    for (int i = NW - 1; i >= 0; i--) if (mask[i]) exp_first = exp_addr(i);
    chk({tag, "_nwrites"}, 32'(wlog_addr.size()), 32'(NW));
    chk({tag, "_nreads"}, 32'(rlog_addr.size()), 32'(NW));
    for (int i = 0; i < NW && i < wlog_addr.size(); i++) begin
      chk($sformatf("%s_waddr%0d", tag, i), wlog_addr[i], exp_addr(i));
      chk($sformatf("%s_wdata%0d", tag, i), wlog_data[i], exp_data(i));
    end
    for (int i = 0; i < NW && i < rlog_addr.size(); i++)
      chk($sformatf("%s_raddr%0d", tag, i), rlog_addr[i], exp_addr(i));
    chk({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
    chk({tag, "_first_err"}, first_err_addr, exp_first);
    chk({tag, "_pass"}, 32'(pass), 32'(exp_err == 0));
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_stable"}, 32'({aw_unstable, w_unstable}), 32'd0);
  endtask

  initial begin
    logic [31:0] lit [NW];
    bit          saw_valid;
    logic [NW-1:0] m;
    lit[0] = 32'hDEAD_BEEF; lit[1] = 32'hDFAE_BFF0; lit[2] = 32'hE0AF_C0F1; lit[3] = 32'hE1B0_C1F2;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_first_err", first_err_addr, 32'd0);
    chk("rst_valids", 32'({mem_axi_awvalid, mem_axi_wvalid, mem_axi_arvalid}), 32'd0);
    chk("rst_readies", 32'({mem_axi_bready, mem_axi_rready}), 32'd0);
    chk("const_prot_strb", 32'({mem_axi_awprot, mem_axi_arprot, mem_axi_wstrb}), 32'h00F);
    resetn = 1;

    // Zero-wait responder with the literal pattern.
    start_run();
    chk("t1_busy_after_start", 32'(busy), 32'd1);
    chk("t1_first_awaddr", mem_axi_awaddr, BASE);
    wait_done("t1");
    for (int i = 0; i < NW && i < wlog_data.size(); i++)
      chk($sformatf("t1_literal%0d", i), wlog_data[i], lit[i]);
    check_full_run("t1", '0);

    // awready stalls 3 cycles, wready immediate.
    aw_delay = 3; w_delay = 0;
    start_run();
    wait_done("t2");
    check_full_run("t2", '0);
    chk("t2_n_aw", 32'(aw_hi.size()), 32'(NW));
    for (int i = 0; i < aw_hi.size(); i++) begin
      chk($sformatf("t2_aw_hi%0d", i), 32'(aw_hi[i]), 32'd4);
      chk($sformatf("t2_w_hi%0d", i), 32'(w_hi[i]), 32'd1);
    end
    chk("t2_n_bresp", 32'(n_b), 32'(NW));
    aw_delay = 0;

    // Readback of word 2 corrupted.
    corrupt_mask = 4'b0100;
    start_run();
    wait_done("t3");
    check_full_run("t3", 4'b0100);
    chk("t3_first_err_lit", first_err_addr, 32'h0000_1008);
    corrupt_mask = '0;

    // Restart from DONE clears status; start while busy is ignored.
    start_run();
    chk("t6_done_cleared", 32'(done), 32'd0);
    chk("t6_err_cleared", 32'(err_count), 32'd0);
    chk("t6_first_cleared", first_err_addr, 32'd0);
    chk("t6_busy", 32'(busy), 32'd1);
    repeat (3) begin
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
    end
    wait_done("t6");
    check_full_run("t6", '0);
    chk("t6_n_bresp", 32'(n_b), 32'(NW));

    // Random stalls and random corrupted readbacks.
    rand_delays = 1;
    for (int r = 0; r < 4; r++) begin
      m = NW'($urandom_range(0, (1 << NW) - 1));
      corrupt_mask = m;
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      start_run();
      wait_done($sformatf("rnd%0d", r));
      check_full_run($sformatf("rnd%0d", r), m);
    end
    rand_delays = 0; corrupt_mask = '0; aw_delay = 0; w_delay = 0;

    // arready never asserted: read address stall times out.
    ar_enable = 0;
    start_run();
    wait_done("t4");
    chk("t4_arvalid_cycles", 32'(arv_cycles), 32'(TO));
    chk("t4_timeout", 32'(timeout), 32'd1);
    chk("t4_pass", 32'(pass), 32'd0);
    chk("t4_arvalid_low", 32'(mem_axi_arvalid), 32'd0);
    chk("t4_writes_done", 32'(n_b), 32'(NW));
    ar_enable = 1;

    // Asynchronous reset in the middle of a stalled write.
    aw_delay = 10;
    start_run();
    chk("t5_awvalid_before", 32'(mem_axi_awvalid), 32'd1);
    #2 resetn = 0;
    #1;
    chk("t5_async_valids", 32'({mem_axi_awvalid, mem_axi_wvalid}), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1;
    aw_delay = 0;
    saw_valid = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_axi_awvalid || mem_axi_wvalid || mem_axi_arvalid || busy || done) saw_valid = 1;
    end
    chk("t5_idle_after_reset", 32'(saw_valid), 32'd0);
    start_run();
    wait_done("t5");
    check_full_run("t5", '0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
